// File: rtl/alu_arb_2ch.sv
// Round-robin two-channel front end for the shared 4-bit registered ALU.
// Optional macro ALU_ARB_OPCHECK_EN: opcode 3'b111 is answered locally with rsp_err=1.
module alu_arb_2ch #(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_0,
  input  logic       req_valid_1,
  output logic       req_ready_0,
  output logic       req_ready_1,
  input  logic [3:0] req_a_0,
  input  logic [3:0] req_a_1,
  input  logic [3:0] req_b_0,
  input  logic [3:0] req_b_1,
  input  logic [2:0] req_op_0,
  input  logic [2:0] req_op_1,
  output logic       rsp_valid_0,
  output logic       rsp_valid_1,
  input  logic       rsp_ready_0,
  input  logic       rsp_ready_1,
  output logic [4:0] rsp_data,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [4:0] alu_result,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t     state_q;
  logic       ptr_q, chan_q;
  logic [3:0] a_q, b_q;
  logic [2:0] op_q;
  logic [4:0] data_q;
  logic       zero_q;
  logic       gnt_0, gnt_1, acc, acc_ch, illegal, rsp_done;
  logic [3:0] sel_a, sel_b;
  logic [2:0] sel_op;

  // A lone requester always wins; the pointer only breaks ties.
  assign gnt_0  = req_valid_0 & (~req_valid_1 | ~ptr_q);
  assign gnt_1  = req_valid_1 & (~req_valid_0 |  ptr_q);
  assign req_ready_0 = rst_n & (state_q == IDLE) & gnt_0;
  assign req_ready_1 = rst_n & (state_q == IDLE) & gnt_1;
  assign acc    = req_ready_0 | req_ready_1;
  assign acc_ch = req_ready_1;
  assign sel_a  = acc_ch ? req_a_1  : req_a_0;
  assign sel_b  = acc_ch ? req_b_1  : req_b_0;
  assign sel_op = acc_ch ? req_op_1 : req_op_0;

`ifdef ALU_ARB_OPCHECK_EN
  assign illegal = (sel_op == 3'b111);
`else
  assign illegal = 1'b0;
`endif

  assign rsp_done    = (state_q == RESP) & (chan_q ? rsp_ready_1 : rsp_ready_0);
  assign rsp_valid_0 = (state_q == RESP) & ~chan_q;
  assign rsp_valid_1 = (state_q == RESP) &  chan_q;
  assign rsp_data    = data_q;
  assign rsp_zero    = zero_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= RESET_PRIO;
      chan_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (acc) begin
          chan_q <= acc_ch;
          if (illegal) begin
            // Answered locally; ALU operands keep their previous values.
            data_q  <= '0;
            zero_q  <= 1'b1;
            state_q <= RESP;
          end else begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            op_q    <= sel_op;
            state_q <= EXEC;
          end
        end
        EXEC: state_q <= CAPT;
        CAPT: begin
          data_q  <= alu_result;
          zero_q  <= (alu_result == 5'd0);
          state_q <= RESP;
        end
        RESP: if (rsp_done) begin
          ptr_q   <= ~chan_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       err_q <= 1'b0;
    else if (state_q == IDLE && acc)  err_q <= illegal;
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arb_2ch.sv
// Randomized self-checking bench for alu_arb_2ch with a behavioural ALU and arbiter model.
module tb_alu_arb_2ch;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [3:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic [2:0] req_op_0, req_op_1;
  logic       rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
  logic [4:0] rsp_data;
  logic       rsp_zero, rsp_err;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [4:0] alu_result = 5'd0;
  logic       busy;

`ifdef ALU_ARB_OPCHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  int nchk = 0, nfail = 0;
  int ptr_m = 0;
  logic [3:0] last_a = 0, last_b = 0;
  logic [2:0] last_op = 0;

  alu_arb_2ch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1), .req_b_0(req_b_0), .req_b_1(req_b_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared registered ALU.
  always @(posedge clk) begin
    case (alu_op)
      3'd0: alu_result <= {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_result <= {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_result <= {1'b0, alu_a & alu_b};
      3'd3: alu_result <= {1'b0, alu_a | alu_b};
      3'd4: alu_result <= {1'b0, alu_a ^ alu_b};
      3'd5: alu_result <= {alu_a, 1'b0};
      3'd6: alu_result <= {2'b0, alu_a[3:1]};
      default: alu_result <= 5'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_res(input int a, input int b, input int op);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b + 32;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a * 2;
      6: r = a / 2;
      default: r = 0;
    endcase
    return 5'(r % 32);
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic txn(input bit v0, input bit v1,
                     input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] o0,
                     input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] o1,
                     input int hold);
    int w, lat;
    bit ill;
    logic [3:0] wa, wb;
    logic [2:0] wo;
    logic [4:0] er;
    w = (v0 && v1) ? ptr_m : (v1 ? 1 : 0);
    req_valid_0 = v0; req_a_0 = a0; req_b_0 = b0; req_op_0 = o0;
    req_valid_1 = v1; req_a_1 = a1; req_b_1 = b1; req_op_1 = o1;
    #1;
    chk("rdy_win", w ? req_ready_1 : req_ready_0, 1);
    chk("rdy_lose", w ? req_ready_0 : req_ready_1, 0);
    if (!(req_ready_0 || req_ready_1)) begin
      req_valid_0 = 0; req_valid_1 = 0;
      @(negedge clk);
      return;
    end
    wa = w ? a1 : a0; wb = w ? b1 : b0; wo = w ? o1 : o0;
    ill = OPCHK && (wo == 3'd7);
    lat = ill ? 1 : 3;
    er  = ill ? 5'd0 : ref_res(wa, wb, wo);
    if (!ill) begin last_a = wa; last_b = wb; last_op = wo; end
    @(negedge clk);
    req_valid_0 = 0; req_valid_1 = 0;
    for (int k = 1; k < lat; k++) begin
      chk("early_rsp", {rsp_valid_0, rsp_valid_1}, 0);
      chk("busy_mid", busy, 1);
      if (k == 1) chk("alu_drive", {alu_a, alu_b, alu_op}, {wa, wb, wo});
      @(negedge clk);
    end
    chk("rsp_win", w ? rsp_valid_1 : rsp_valid_0, 1);
    chk("rsp_other", w ? rsp_valid_0 : rsp_valid_1, 0);
    chk("rsp_data", rsp_data, er);
    chk("rsp_zero", rsp_zero, er == 0);
    chk("rsp_err", rsp_err, ill);
    chk("alu_hold", {alu_a, alu_b, alu_op}, {last_a, last_b, last_op});
    req_valid_0 = 1; req_valid_1 = 1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_vld", w ? rsp_valid_1 : rsp_valid_0, 1);
      chk("hold_data", {rsp_data, rsp_zero, rsp_err}, {er, er == 0, ill});
      chk("hold_rdy", {req_ready_0, req_ready_1}, 0);
    end
    req_valid_0 = 0; req_valid_1 = 0;
    rsp_ready_0 = 1; rsp_ready_1 = 1;
    @(negedge clk);
    rsp_ready_0 = 0; rsp_ready_1 = 0;
    ptr_m = 1 - w;
    chk("idle_busy", busy, 0);
    chk("idle_vld", {rsp_valid_0, rsp_valid_1}, 0);
  endtask

  initial begin
    rst_n = 0;
    req_valid_0 = 0; req_valid_1 = 0; rsp_ready_0 = 0; rsp_ready_1 = 0;
    req_a_0 = 0; req_a_1 = 0; req_b_0 = 0; req_b_1 = 0; req_op_0 = 0; req_op_1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_data,
                     rsp_zero, rsp_err, alu_a, alu_b, alu_op, busy}, 0);
    rst_n = 1;
    @(negedge clk);

    txn(1, 0, 4'hF, 4'h1, 3'd0, 0, 0, 0, 0);
    txn(0, 1, 0, 0, 0, 4'h5, 4'h5, 3'd1, 0);
    txn(0, 1, 0, 0, 0, 4'h3, 4'h5, 3'd1, 1);
    for (int i = 0; i < 4; i++) txn(1, 1, 4'hF, 4'h3, 3'd2, 4'hA, 4'h5, 3'd4, 0);
    txn(1, 0, 4'h9, 0, 3'd5, 0, 0, 0, 10);
    txn(1, 0, 4'h6, 4'h2, 3'd7, 0, 0, 0, 0);

    // Reset during EXEC of a ch1 OR.
    req_valid_1 = 1; req_a_1 = 4'h4; req_b_1 = 4'h2; req_op_1 = 3'd3;
    #1;
    chk("or_rdy", req_ready_1, 1);
    @(negedge clk);
    req_valid_1 = 0;
    chk("or_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("midrst_outs", {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_data,
                        rsp_zero, rsp_err, alu_a, alu_b, alu_op, busy}, 0);
    @(negedge clk);
    rst_n = 1;
    ptr_m = 0; last_a = 0; last_b = 0; last_op = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_norsp", {rsp_valid_0, rsp_valid_1}, 0);
    end
    txn(1, 1, 4'h7, 4'h1, 3'd0, 4'h2, 4'h2, 3'd1, 0);

    for (int i = 0; i < 40; i++) begin
      bit v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      txn(v0, v1, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)),
          4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_arb_2ch.md
# alu_arb_2ch

Two-channel arbiter and sequencer for the shared 4-bit registered ALU. Accepts operation requests from two independent requesters over valid/ready handshakes and grants them round-robin. Drives the ALU operand/opcode inputs, waits out the ALU's one-cycle register latency, captures the 5-bit result, and returns it with a locally computed zero flag to the granted requester. Sits between the requesting control units and the single ALU instance.

## Interface
- `RESET_PRIO`, default 0: channel favoured on the first arbitration after reset (0 or 1).

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid_0` / `req_valid_1`  in  1  request valid, per channel
- `req_ready_0` / `req_ready_1`  out  1  request accepted, per channel
- `req_a_0` / `req_a_1`  in  4  operand A, per channel
- `req_b_0` / `req_b_1`  in  4  operand B, per channel
- `req_op_0` / `req_op_1`  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR
- `rsp_valid_0` / `rsp_valid_1`  out  1  response valid, per channel
- `rsp_ready_0` / `rsp_ready_1`  in  1  response consumed, per channel
- `rsp_data`  out  5  result, shared by both channels
- `rsp_zero`  out  1  high when `rsp_data` == 0
- `rsp_err`  out  1  illegal-opcode flag; see Configuration
- `alu_a` / `alu_b`  out  4  ALU operands
- `alu_op`  out  3  ALU opcode
- `alu_result`  in  5  registered ALU result
- `busy`  out  1  high in any state other than IDLE

## Operation
- The FSM has four states: IDLE, EXEC, CAPT and RESP.
- IDLE:
  - `req_ready_x` = IDLE & grant_x. Grant is combinational.
  - If only one channel is valid, that channel wins.
  - If both are valid, the channel named by the priority pointer wins.
  - On handshake, latch a, b and op into operand registers, record the granted channel, and go to EXEC.
- EXEC: operand registers drive `alu_a`/`alu_b`/`alu_op`. The ALU samples them at the end of this cycle. Go to CAPT.
- CAPT:
  - `alu_result` is valid.
  - Register `rsp_data` = `alu_result` and `rsp_zero` = (`alu_result` == 0).
  - Go to RESP.
- RESP:
  - `rsp_valid` is asserted for the granted channel only.
  - `rsp_data`, `rsp_zero` and `rsp_err` hold stable until the response handshake completes.
  - On `rsp_valid_x & rsp_ready_x`: pointer = the other channel, then go to IDLE.
- `alu_*` outputs hold the last latched operands outside EXEC.
- Arithmetic is passed through unmodified, including 5-bit wrap. Example: SUB 3-5 returns 5'h1E with `rsp_zero`=0.
- A lone requester may be served back-to-back; the pointer never blocks a solitary request.
- A request that drops `req_valid` before grant is simply not served. No state is kept for it.
- Only one operation is in flight at a time. No request is accepted outside IDLE.

## Timing
- Handshake at edge T. EXEC runs in T+1, CAPT in T+2, and `rsp_valid` is high from T+3.
- Response-handshake edge to next request acceptance: that edge returns the FSM to IDLE, so acceptance is possible at the following edge. Minimum period is 4 cycles per operation.
- Reset values, all outputs: `req_ready_*`=0, `rsp_valid_*`=0, `rsp_data`=0, `rsp_zero`=0, `rsp_err`=0, `alu_a`=`alu_b`=0, `alu_op`=0, `busy`=0.
- Reset state: FSM in IDLE, pointer = `RESET_PRIO`.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronously). The in-flight operation is discarded and no response is issued.
- `rsp_ready` held low: the FSM stays in RESP indefinitely with outputs stable. Both `req_ready` signals stay 0.

## Configuration
- `ALU_ARB_OPCHECK_EN` defined:
  - Opcode 3'b111 is accepted, but the FSM skips EXEC and CAPT and goes IDLE→RESP.
  - The response is `rsp_data`=0, `rsp_zero`=1, `rsp_err`=1.
  - `alu_*` outputs are not updated.
  - Total latency is 1 cycle (`rsp_valid` at T+1).
- `ALU_ARB_OPCHECK_EN` not defined:
  - 3'b111 is sequenced like any other opcode, and the ALU returns 0.
  - `rsp_err` is tied to 0.

## Test plan
- Ch0 ADD a=4'hF b=4'h1 → `rsp_valid_0` at T+3, `rsp_data`=5'h10, `rsp_zero`=0, `rsp_valid_1`=0.
- Ch1 SUB a=5 b=5 → `rsp_valid_1` at T+3, `rsp_data`=0, `rsp_zero`=1.
- After reset with `RESET_PRIO`=0, both channels request simultaneously (ch0 AND F&3, ch1 XOR A^5) → ch0 served first (5'h03), then ch1 (5'h0F). Repeat with both held valid → order alternates 0,1,0,1.
- Ch0 SHL a=4'h9 with `rsp_ready_0` low for 10 cycles → `rsp_valid_0` held, `rsp_data`=5'h12 stable, `req_ready_1`=0 throughout; release → IDLE next cycle.
- Assert `rst_n`=0 during EXEC of ch1 OR → all outputs 0 at once, no `rsp_valid`; after release, ch0 is granted first on a simultaneous request.
- With `ALU_ARB_OPCHECK_EN`, ch0 op=3'b111 → `rsp_valid_0` at T+1, `rsp_err`=1, `rsp_data`=0, `rsp_zero`=1. Without the macro → T+3, `rsp_err`=0, `rsp_data`=0.
